// File: rtl/fifo_pixel_unpacker.sv
// fifo_pixel_unpacker
//
// Pops 32-bit words from a show-ahead FIFO read port and splits each word
// into two RGB565 pixels. The pixels leave on a valid/ready stream tagged with
// line and frame markers. The block sustains one pixel per clock: the first
// half of a word goes straight to the output register, and the second half
// waits in a one-entry hold register.
//
// Optional feature: define PIX_UNPACK_UNDERFLOW_CNT_EN to add a saturating
// 16-bit FIFO-underflow counter and its clear input.
//
// Ports:
//   clk            single clock (FIFO read / pixel clock)
//   rst_n          asynchronous active-low reset
//   frame_start    1-cycle pulse: start a frame, or abort and restart one
//   fifo_rd_en     pop strobe to the FIFO (combinational)
//   fifo_rd_vld    FIFO read data valid
//   fifo_rd_data   FIFO read data (show-ahead)
//   pix_valid      output pixel valid
//   pix_ready      downstream ready
//   pix_data       RGB565 pixel
//   pix_sol/eol    first/last pixel of a line
//   pix_sof/eof    first/last pixel of a frame
//   frame_done     1-cycle pulse after the eof pixel is accepted
//   busy           block is not idle
//   underflow_clr  (optional) clears underflow_cnt on the next cycle
//   underflow_cnt  (optional) saturating count of underflow cycles
module fifo_pixel_unpacker #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int HCNT_W    = 11,
  parameter int VCNT_W    = 10,
  parameter int LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  output logic        fifo_rd_en,
  input  logic        fifo_rd_vld,
  input  logic [31:0] fifo_rd_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic        pix_sol,
  output logic        pix_eol,
  output logic        pix_sof,
  output logic        pix_eof,
  output logic        frame_done,
  output logic        busy
`ifdef PIX_UNPACK_UNDERFLOW_CNT_EN
  ,
  input  logic        underflow_clr,
  output logic [15:0] underflow_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [HCNT_W-1:0] X_LAST = HCNT_W'(H_ACTIVE - 1);
  localparam logic [VCNT_W-1:0] Y_LAST = VCNT_W'(V_ACTIVE - 1);

  logic [1:0]        state_q, state_d;
  logic [HCNT_W-1:0] x_q, x_d;
  logic [VCNT_W-1:0] y_q, y_d;
  logic [15:0]       hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic              pix_valid_q, pix_valid_d;
  logic [15:0]       pix_data_q, pix_data_d;
  logic              sol_q, sol_d;
  logic              eol_q, eol_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              frame_done_q, frame_done_d;

  logic [15:0] first_half;
  logic [15:0] second_half;
  logic        load_ok;
  logic        accept;
  logic        load_hold;
  logic        load_word;
  logic        at_eol;
  logic        at_eof;

  // Pixel order within a word.
  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign first_half  = fifo_rd_data[15:0];
      assign second_half = fifo_rd_data[31:16];
    end else begin : g_msb_first
      assign first_half  = fifo_rd_data[31:16];
      assign second_half = fifo_rd_data[15:0];
    end
  endgenerate

  always_comb begin
    load_ok = !pix_valid_q || pix_ready;
    accept  = pix_valid_q && pix_ready;
    at_eol  = (x_q == X_LAST);
    at_eof  = at_eol && (y_q == Y_LAST);
    // A pending half-word always goes first; a pop only happens with an
    // empty hold register. frame_start suppresses both so that a word is
    // never popped only to be thrown away by the restart.
    load_hold = (state_q == ST_RUN) && !frame_start && load_ok && hold_vld_q;
    load_word = (state_q == ST_RUN) && !frame_start && load_ok && !hold_vld_q && fifo_rd_vld;
  end

  assign fifo_rd_en = load_word;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    pix_valid_d  = pix_valid_q;
    pix_data_d   = pix_data_q;
    sol_d        = sol_q;
    eol_d        = eol_q;
    sof_d        = sof_q;
    eof_d        = eof_q;
    frame_done_d = 1'b0;

    if (frame_start) begin
      // Start or restart: any pending half-word and output pixel are dropped.
      state_d     = ST_RUN;
      x_d         = '0;
      y_d         = '0;
      hold_vld_d  = 1'b0;
      pix_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load_hold || load_word) begin
            pix_valid_d = 1'b1;
            pix_data_d  = load_hold ? hold_q : first_half;
            sol_d       = (x_q == '0);
            eol_d       = at_eol;
            sof_d       = (x_q == '0) && (y_q == '0);
            eof_d       = at_eof;
            if (load_word) begin
              hold_d     = second_half;
              hold_vld_d = 1'b1;
            end else begin
              hold_vld_d = 1'b0;
            end
            if (at_eol) begin
              x_d = '0;
              y_d = y_q + VCNT_W'(1);
            end else begin
              x_d = x_q + HCNT_W'(1);
            end
            if (at_eof) begin
              state_d = ST_DONE;
            end
          end else if (accept) begin
            pix_valid_d = 1'b0;
          end
        end
        ST_DONE: begin
          // Only the eof pixel can be in the output register here.
          if (accept) begin
            pix_valid_d = 1'b0;
            if (eof_q) begin
              frame_done_d = 1'b1;
              state_d      = ST_IDLE;
            end
          end
        end
        default: begin
          if (accept) begin
            pix_valid_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      sol_q        <= 1'b0;
      eol_q        <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      sol_q        <= sol_d;
      eol_q        <= eol_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_sol    = sol_q;
  assign pix_eol    = eol_q;
  assign pix_sof    = sof_q;
  assign pix_eof    = eof_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef PIX_UNPACK_UNDERFLOW_CNT_EN
  logic        underflow;
  logic [15:0] uf_cnt_q, uf_cnt_d;

  // RUN always has pixels remaining: the eof load moves the state to DONE.
  always_comb begin
    underflow = (state_q == ST_RUN) && load_ok && !hold_vld_q && !fifo_rd_vld;
    uf_cnt_d  = uf_cnt_q;
    if (underflow_clr) begin
      uf_cnt_d = '0;
    end else if (underflow && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_d = uf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uf_cnt_q <= '0;
    end else begin
      uf_cnt_q <= uf_cnt_d;
    end
  end

  assign underflow_cnt = uf_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_pixel_unpacker.sv
module tb_fifo_pixel_unpacker;
  localparam int H = 4;
  localparam int V = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, frame_start, fifo_rd_en, pix_ready;
  logic        fifo_rd_vld = 1'b0;
  logic [31:0] fifo_rd_data = 32'h0;
  logic        pix_valid, pix_sol, pix_eol, pix_sof, pix_eof, frame_done, busy;
  logic [15:0] pix_data;

  logic        fs2, rd_en2, vld2, valid2, ready2, sol2, eol2, sof2, eof2, done2, busy2;
  logic [31:0] data2;
  logic [15:0] pdata2;
`ifdef PIX_UNPACK_UNDERFLOW_CNT_EN
  logic        underflow_clr, clr2;
  logic [15:0] underflow_cnt, cnt2;
`endif

  fifo_pixel_unpacker #(.H_ACTIVE(H), .V_ACTIVE(V), .HCNT_W(3), .VCNT_W(2), .LSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof), .pix_eof(pix_eof),
    .frame_done(frame_done), .busy(busy)
`ifdef PIX_UNPACK_UNDERFLOW_CNT_EN
    , .underflow_clr(underflow_clr), .underflow_cnt(underflow_cnt)
`endif
  );

  fifo_pixel_unpacker #(.H_ACTIVE(H), .V_ACTIVE(V), .HCNT_W(3), .VCNT_W(2), .LSB_FIRST(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .frame_start(fs2),
    .fifo_rd_en(rd_en2), .fifo_rd_vld(vld2), .fifo_rd_data(data2),
    .pix_valid(valid2), .pix_ready(ready2), .pix_data(pdata2),
    .pix_sol(sol2), .pix_eol(eol2), .pix_sof(sof2), .pix_eof(eof2),
    .frame_done(done2), .busy(busy2)
`ifdef PIX_UNPACK_UNDERFLOW_CNT_EN
    , .underflow_clr(clr2), .underflow_cnt(cnt2)
`endif
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Show-ahead FIFO model: pops on rd_en at the edge, new head visible after it.
  logic [31:0] fq[$];
  logic        vld_gate = 1'b0;
  int          pops = 0;
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_rd_vld && fq.size() != 0) begin
      void'(fq.pop_front());
      pops++;
    end
    #1;
    if (fq.size() != 0) begin
      fifo_rd_vld  = vld_gate;
      fifo_rd_data = fq[0];
    end else begin
      fifo_rd_vld  = 1'b0;
      fifo_rd_data = 32'h0;
    end
  end

  // Reference model: the pixel stream of one frame follows from the word list
  // alone (k-th pixel sits at x=k%H, y=k/H).
  typedef struct packed {
    logic [15:0] d;
    logic sol, eol, sof, eof;
  } pix_t;
  pix_t exp_q[$];
  logic sb_en = 1'b0;

  task automatic build_expected(input logic [31:0] w0, w1, w2, w3);
    logic [31:0] ws[4];
    pix_t p;
    ws = '{w0, w1, w2, w3};
    for (int k = 0; k < H * V; k++) begin
      p.d   = (k % 2 == 0) ? ws[k / 2][15:0] : ws[k / 2][31:16];
      p.sol = (k % H == 0);
      p.eol = (k % H == H - 1);
      p.sof = (k == 0);
      p.eof = (k == H * V - 1);
      exp_q.push_back(p);
    end
  endtask

  // Scoreboard / protocol monitor, sampling 1 time unit after the falling edge.
  pix_t cur_pix, prev_pix, exp_pix;
  logic prev_stall = 1'b0;
  logic done_exp = 1'b0;
  always @(negedge clk) begin
    #1;
    if (rst_n && fifo_rd_en) chk("pop_needs_vld", {63'h0, fifo_rd_vld}, 64'h1);
    if (sb_en) begin
      cur_pix = '{pix_data, pix_sol, pix_eol, pix_sof, pix_eof};
      if (prev_stall) chk("stall_stable", {pix_valid, cur_pix}, {1'b1, prev_pix});
      chk("frame_done", {63'h0, frame_done}, {63'h0, done_exp});
      done_exp = 1'b0;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL extra_pixel: got %h expected no pixel", cur_pix);
        end else begin
          exp_pix = exp_q.pop_front();
          chk("pixel", cur_pix, exp_pix);
          if (exp_pix.eof) done_exp = 1'b1;
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = cur_pix;
    end else begin
      prev_stall = 1'b0;
      done_exp   = 1'b0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; frame_start = 1'b0; fs2 = 1'b0; pix_ready = 1'b0;
    vld_gate = 1'b0; sb_en = 1'b0;
    fq.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vld_gate = 1'b1;
  endtask

  // mode 0: ready=1, 1: ready toggles, 2: random ready and FIFO gaps
  task automatic run_until_done(input int budget, input int mode, output logic seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      frame_start = 1'b0;
      case (mode)
        0: pix_ready = 1'b1;
        1: pix_ready = c[0];
        default: begin
          pix_ready = 1'($urandom_range(0, 1));
          vld_gate  = ($urandom_range(0, 3) != 0);
        end
      endcase
      #1;
      if (frame_done) seen = 1'b1;
    end
    vld_gate = 1'b1;
  endtask

  typedef struct {
    logic        ready;
    logic        rd_en;
    logic        valid;
    logic [15:0] data;
    logic [3:0]  mk;     // {sol, eol, sof, eof}
    logic        done;
    logic        busy;
  } vec_t;
  vec_t tv[11];

  int   p0;
  logic seen;
  logic [31:0] rw[4];

  initial begin
    tv[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b1};
    tv[1]  = '{1'b1, 1'b0, 1'b1, 16'h1111, 4'b1010, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 1'b1, 1'b1, 16'h2222, 4'b0000, 1'b0, 1'b1};
    tv[3]  = '{1'b1, 1'b0, 1'b1, 16'h3333, 4'b0000, 1'b0, 1'b1};
    tv[4]  = '{1'b1, 1'b1, 1'b1, 16'h4444, 4'b0100, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 1'b0, 1'b1, 16'h5555, 4'b1000, 1'b0, 1'b1};
    tv[6]  = '{1'b1, 1'b1, 1'b1, 16'h6666, 4'b0000, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 1'b0, 1'b1, 16'h7777, 4'b0000, 1'b0, 1'b1};
    tv[8]  = '{1'b1, 1'b0, 1'b1, 16'h8888, 4'b0101, 1'b0, 1'b1};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0};
    tv[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0};

    rst_n = 1'b0; frame_start = 1'b0; pix_ready = 1'b0;
    fs2 = 1'b0; vld2 = 1'b0; data2 = 32'h0; ready2 = 1'b1;
`ifdef PIX_UNPACK_UNDERFLOW_CNT_EN
    underflow_clr = 1'b0; clr2 = 1'b0;
`endif

    // Reset held with random inputs, then idle without frame_start.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      frame_start = 1'($urandom_range(0, 1));
      pix_ready   = 1'($urandom_range(0, 1));
      vld_gate    = 1'($urandom_range(0, 1));
      fq.push_back($urandom);
      #1;
      chk("reset_outs", {pix_valid, fifo_rd_en, busy, frame_done, pix_data,
                         pix_sol, pix_eol, pix_sof, pix_eof}, 64'h0);
    end
    @(negedge clk);
    frame_start = 1'b0; vld_gate = 1'b1; rst_n = 1'b1;
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("idle_no_pop", {fifo_rd_en, busy, pix_valid}, 64'h0);
    end
    chk("idle_pop_count", pops - p0, 0);

    // Table-driven basic frame, ready held high.
    do_reset();
    fq.push_back(32'h22221111); fq.push_back(32'h44443333);
    fq.push_back(32'h66665555); fq.push_back(32'h88887777);
    p0 = pops;
    @(negedge clk);
    frame_start = 1'b1; pix_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      frame_start = 1'b0;
      pix_ready = tv[i].ready;
      #1;
      if (tv[i].valid)
        chk($sformatf("vec%0d", i),
            {fifo_rd_en, pix_valid, frame_done, busy, pix_data, pix_sol, pix_eol, pix_sof, pix_eof},
            {tv[i].rd_en, tv[i].valid, tv[i].done, tv[i].busy, tv[i].data, tv[i].mk});
      else
        chk($sformatf("vec%0d", i), {fifo_rd_en, pix_valid, frame_done, busy},
            {tv[i].rd_en, tv[i].valid, tv[i].done, tv[i].busy});
    end
    chk("table_pops", pops - p0, 4);

    // Same frame with ready toggling.
    do_reset();
    fq.push_back(32'h22221111); fq.push_back(32'h44443333);
    fq.push_back(32'h66665555); fq.push_back(32'h88887777);
    build_expected(32'h22221111, 32'h44443333, 32'h66665555, 32'h88887777);
    p0 = pops; sb_en = 1'b1;
    @(negedge clk);
    frame_start = 1'b1;
    run_until_done(80, 1, seen);
    chk("toggle_done_seen", seen, 1);
    chk("toggle_pops", pops - p0, 4);
    chk("toggle_all_pixels", exp_q.size(), 0);

    // FIFO runs dry for 3 cycles after the second word.
    do_reset();
    fq.push_back(32'h22221111); fq.push_back(32'h44443333);
    build_expected(32'h22221111, 32'h44443333, 32'h66665555, 32'h88887777);
    sb_en = 1'b1;
    @(negedge clk);
    frame_start = 1'b1; pix_ready = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (n == 6) begin
        #1;
        chk("uf_valid_drop", pix_valid, 0);
      end
      if (n == 7) begin
        fq.push_back(32'h66665555); fq.push_back(32'h88887777);
      end
    end
    run_until_done(60, 0, seen);
    chk("uf_done_seen", seen, 1);
    chk("uf_all_pixels", exp_q.size(), 0);
`ifdef PIX_UNPACK_UNDERFLOW_CNT_EN
    chk("uf_cnt", underflow_cnt, 3);
    @(negedge clk);
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    #1;
    chk("uf_clr", underflow_cnt, 0);
`endif

    // Abort with 4444 pending in the hold register.
    do_reset();
    fq.push_back(32'h22221111); fq.push_back(32'h44443333);
    fq.push_back(32'h66665555); fq.push_back(32'h88887777);
    @(negedge clk);
    frame_start = 1'b1; pix_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      frame_start = 1'b0;
    end
    @(negedge clk);
    frame_start = 1'b1;
    #1;
    chk("abort_pre", {pix_valid, pix_data}, {1'b1, 16'h3333});
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    chk("abort_flush", {pix_valid, frame_done, busy}, 3'b001);
    build_expected(32'h66665555, 32'h88887777, 32'hAAAA9999, 32'hCCCCBBBB);
    fq.push_back(32'hAAAA9999); fq.push_back(32'hCCCCBBBB);
    sb_en = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_first", {pix_valid, pix_data, pix_sof, pix_sol}, {1'b1, 16'h5555, 1'b1, 1'b1});
    run_until_done(60, 0, seen);
    chk("abort_done_seen", seen, 1);
    chk("abort_all_pixels", exp_q.size(), 0);

    // Reversed half-word order on the second instance.
    do_reset();
    @(negedge clk);
    fs2 = 1'b1; vld2 = 1'b1; data2 = 32'hAAAABBBB;
    @(negedge clk);
    fs2 = 1'b0;
    #1;
    chk("lsb0_pop", rd_en2, 1);
    @(negedge clk);
    vld2 = 1'b0;
    #1;
    chk("lsb0_first", {valid2, pdata2}, {1'b1, 16'hAAAA});
    @(negedge clk);
    #1;
    chk("lsb0_second", {valid2, pdata2}, {1'b1, 16'hBBBB});

    // Random frames: random data, random ready, random FIFO gaps.
    do_reset();
    for (int f = 0; f < 15; f++) begin
      for (int i = 0; i < 4; i++) begin
        rw[i] = $urandom;
        fq.push_back(rw[i]);
      end
      build_expected(rw[0], rw[1], rw[2], rw[3]);
      p0 = pops; sb_en = 1'b1;
      @(negedge clk);
      frame_start = 1'b1;
      run_until_done(400, 2, seen);
      chk($sformatf("rand%0d_done_seen", f), seen, 1);
      chk($sformatf("rand%0d_pops", f), pops - p0, 4);
      chk($sformatf("rand%0d_all_pixels", f), exp_q.size(), 0);
      exp_q.delete();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
